// File: rtl/aes_mux_pkg.sv
// Shared definitions for the AES block stream multiplexer.
//   - Selection mode encodings driven on the mux 'mode' input.
//   - Grant FSM state encoding (IDLE / LOCKED).
//   - wrap_inc: modulo increment used for the round-robin pointer.
package aes_mux_pkg;

    // Selection modes; 2'b11 falls back to round-robin.
    localparam logic [1:0] MODE_RR  = 2'b00;
    localparam logic [1:0] MODE_FIX = 2'b01;
    localparam logic [1:0] MODE_SEL = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // (idx + 1) mod n, without a divider.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Picks the first asserted request at or after 'ptr', searching upward and wrapping modulo N_IN.
// With ptr tied to zero it degenerates into a fixed lowest-index-first priority encoder.
// Ports:
//   req      in   N_IN    request vector
//   ptr      in   SEL_W   index with highest priority (must be < N_IN)
//   gnt_idx  out  SEL_W   granted index (0 when nothing is requested)
//   gnt_vld  out  1       at least one request is asserted
module rr_arbiter #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [SEL_W-1:0] idx;

    // Walk from the farthest candidate back towards ptr so the closest hit wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = int'(N_IN) - 1; i >= 0; i--) begin
            idx = SEL_W'((32'(ptr) + 32'(i)) % N_IN);
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_block_stream_mux.sv
// N-input registered block multiplexer between the AES block producers and the cipher datapath.
// A channel keeps the grant for a whole multi-block message (until its in_last block).
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   mode         00/11 round-robin, 01 fixed priority, 10 forced select
//   sel          channel used in forced-select mode
//   in_valid     per-channel block valid
//   in_last      per-channel last block of message
//   in_data      channel k in bits [k*DATA_W +: DATA_W]
//   in_ready     per-channel accept, one-hot or zero
//   out_valid    registered output valid
//   out_last     registered last flag
//   out_data     registered block
//   out_src      source channel of the registered block
//   out_ready    downstream accept
module aes_block_stream_mux
    import aes_mux_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned SEL_W  = $clog2(N_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N_IN-1:0]          in_valid,
    input  logic [N_IN-1:0]          in_last,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    output logic [N_IN-1:0]          in_ready,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_src,
    input  logic                     out_ready
);

    state_e           state;
    logic [SEL_W-1:0] lock_idx;
    logic [SEL_W-1:0] rr_ptr;

    logic [SEL_W-1:0] arb_ptr;
    logic [SEL_W-1:0] arb_idx;
    logic             arb_vld;
    logic [SEL_W-1:0] grant;
    logic             gnt_vld;
    logic             load_en;
    logic             accept;
    logic             grant_last;

    // Fixed priority reuses the rotating arbiter with the pointer pinned at channel 0.
    always_comb begin
        arb_ptr = (mode == MODE_FIX) ? '0 : rr_ptr;
    end

    rr_arbiter #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (arb_ptr),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // While LOCKED the owner of the current message keeps the grant whatever mode/sel say.
    always_comb begin
        grant   = arb_idx;
        gnt_vld = arb_vld;
        if (state == ST_LOCKED) begin
            grant   = lock_idx;
            gnt_vld = in_valid[lock_idx];
        end else if (mode == MODE_SEL) begin
            grant   = sel;
            gnt_vld = (32'(sel) < N_IN) && in_valid[sel];
        end
    end

    // Output register accepts when empty or being drained this cycle.
    always_comb begin
        load_en    = !out_valid || out_ready;
        accept     = rst_n && load_en && gnt_vld;
        grant_last = in_last[grant];
    end

    // Ready depends only on valid/mode/sel/out_ready and the FSM, never on in_data.
    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[grant] = 1'b1;
        end
    end

    // Output register; held stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load_en) begin
            out_valid <= accept;
            if (accept) begin
                out_last <= grant_last;
                out_data <= in_data[32'(grant)*DATA_W +: DATA_W];
                out_src  <= grant;
            end
        end
    end

    // Message-lock FSM and round-robin pointer; the pointer advances per message, not per block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            lock_idx <= '0;
            rr_ptr   <= '0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (!grant_last) begin
                        state    <= ST_LOCKED;
                        lock_idx <= grant;
                    end
                end
                ST_LOCKED: begin
                    if (grant_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (grant_last) begin
                rr_ptr <= SEL_W'(wrap_inc(32'(grant), N_IN));
            end
        end
    end

endmodule

// File: tb/tb_aes_block_stream_mux.sv
// Directed self-checking bench for aes_block_stream_mux (N_IN=4, DATA_W=128).
module tb_aes_block_stream_mux;

    localparam int unsigned N_IN   = 4;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned SEL_W  = 2;

    logic                   clk;
    logic                   rst_n;
    logic [1:0]             mode;
    logic [SEL_W-1:0]       sel;
    logic [N_IN-1:0]        in_valid;
    logic [N_IN-1:0]        in_last;
    logic [N_IN*DATA_W-1:0] in_data;
    logic [N_IN-1:0]        in_ready;
    logic                   out_valid;
    logic                   out_last;
    logic [DATA_W-1:0]      out_data;
    logic [SEL_W-1:0]       out_src;
    logic                   out_ready;

    int n_checks = 0;
    int n_errors = 0;

    aes_block_stream_mux #(
        .N_IN   (N_IN),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] blk(input int ch, input int beat);
        return {32'hA5A5_0000 + 32'(ch), 32'(beat), 32'h1234_5678, 32'(ch) ^ 32'(beat)};
    endfunction

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_data(input int beat);
        for (int k = 0; k < int'(N_IN); k++) begin
            in_data[k*DATA_W +: DATA_W] = blk(k, beat);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int src, input int beat, input logic last);
        check({tag, ".valid"}, 128'(out_valid), 128'(1'b1));
        check({tag, ".src"},   128'(out_src),   128'(src));
        check({tag, ".data"},  128'(out_data),  128'(blk(src, beat)));
        check({tag, ".last"},  128'(out_last),  128'(last));
    endtask

    task automatic check_rdy(input string tag, input logic [N_IN-1:0] exp);
        #1;
        check(tag, 128'(in_ready), 128'(exp));
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 2'b00;
        sel       = '0;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        in_data   = '0;
        out_ready = 1'b1;
        set_data(0);

        // Reset state, with all channels requesting.
        step();
        check("rst.out_valid", 128'(out_valid), 128'(0));
        check("rst.out_last",  128'(out_last),  128'(0));
        check("rst.out_data",  128'(out_data),  128'(0));
        check("rst.out_src",   128'(out_src),   128'(0));
        check("rst.in_ready",  128'(in_ready),  128'(0));

        // Round-robin over single-block messages: 0,1,2,3,0 back to back.
        rst_n = 1'b1;
        check_rdy("rr.first_rdy", 4'b0001);
        for (int b = 0; b < 5; b++) begin
            set_data(b);
            step();
            check_out($sformatf("rr%0d", b), b % 4, b, 1'b1);
        end

        // Mid-cycle async reset clears outputs at once; pointer returns to ch0.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.out_valid", 128'(out_valid), 128'(0));
        check("arst.out_data",  128'(out_data),  128'(0));
        check("arst.in_ready",  128'(in_ready),  128'(0));
        step();
        rst_n = 1'b1;
        check_rdy("arst.first_rdy", 4'b0001);
        set_data(10);
        step();
        check_out("arst.first", 0, 10, 1'b1);

        // Message lock: ch1 sends three blocks while others wait.
        in_last = 4'b1101;
        set_data(20);
        check_rdy("lock.rdy0", 4'b0010);
        step();
        check_out("lock.b0", 1, 20, 1'b0);
        set_data(21);
        check_rdy("lock.rdy1", 4'b0010);
        check("lock.ch0_ready", 128'(in_ready[0]), 128'(0));
        step();
        check_out("lock.b1", 1, 21, 1'b0);
        in_last = 4'b1111;
        set_data(22);
        check_rdy("lock.rdy2", 4'b0010);
        step();
        check_out("lock.b2", 1, 22, 1'b1);
        set_data(23);
        check_rdy("lock.next_rdy", 4'b0100);
        step();
        check_out("lock.next", 2, 23, 1'b1);

        // Backpressure: register holds ch2 block for 5 cycles.
        out_ready = 1'b0;
        check_rdy("bp.rdy", 4'b0000);
        for (int i = 0; i < 5; i++) begin
            set_data(30 + i);
            step();
            check_out($sformatf("bp%0d", i), 2, 23, 1'b1);
            check($sformatf("bp%0d.rdy", i), 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        set_data(40);
        check_rdy("bp.release_rdy", 4'b1000);
        step();
        check_out("bp.release", 3, 40, 1'b1);

        // Fixed priority: lowest valid index.
        mode     = 2'b01;
        in_valid = 4'b1100;
        set_data(50);
        check_rdy("fix.rdy", 4'b0100);
        step();
        check_out("fix", 2, 50, 1'b1);

        // Forced select on an idle channel: no grant, output empties.
        mode     = 2'b10;
        sel      = 2'd3;
        in_valid = 4'b0111;
        check_rdy("sel.none_rdy", 4'b0000);
        step();
        check("sel.none_valid", 128'(out_valid), 128'(0));
        in_valid = 4'b1111;
        set_data(51);
        check_rdy("sel.rdy", 4'b1000);
        step();
        check_out("sel", 3, 51, 1'b1);

        // Lock on ch2 under fixed priority, then switch to forced sel=0 mid-message.
        mode     = 2'b01;
        in_valid = 4'b0100;
        in_last  = 4'b1011;
        set_data(60);
        check_rdy("mchg.rdy0", 4'b0100);
        step();
        check_out("mchg.b0", 2, 60, 1'b0);
        mode     = 2'b10;
        sel      = 2'd0;
        in_valid = 4'b0101;
        set_data(61);
        check_rdy("mchg.rdy1", 4'b0100);
        step();
        check_out("mchg.b1", 2, 61, 1'b0);
        in_last = 4'b1111;
        set_data(62);
        check_rdy("mchg.rdy2", 4'b0100);
        step();
        check_out("mchg.b2", 2, 62, 1'b1);
        set_data(63);
        check_rdy("mchg.sel_rdy", 4'b0001);
        step();
        check_out("mchg.sel", 0, 63, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
